// File: rtl/bus_cycle_scheduler.sv
// bus_cycle_scheduler: 8088 minimum-mode bus cycle arbiter and T-state sequencer (HOLD/HOLDA via BUS_HOLD_EN)
module bus_cycle_scheduler #(
  parameter int MAX_WAIT = 0
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       READY,
  input  logic       HOLD,
  input  logic       pf_req,
  input  logic       suspend,
  input  logic       flush,
  input  logic       ind_req,
  input  logic       ind_io,
  input  logic       ind_wr,
  input  logic       ind_word,
  output logic [2:0] t_state,
  output logic       cyc_ind,
  output logic       byte_hi,
  output logic       ALE,
  output logic       RD_n,
  output logic       WR_n,
  output logic       DEN_n,
  output logic       DTR,
  output logic       IOM,
  output logic       pf_strobe,
  output logic       ind_done,
  output logic       bus_timeout,
  output logic       HOLDA
);
  typedef enum logic [2:0] {TI = 3'd0, T1, T2, T3, TW, T4, TH} state_t;
  state_t state, nxt, arb;
  logic ind_q, io_q, wr_q, word_q, disc, to_q, hold_req;
  logic active, strobe, word_cont, ind_win, pf_win, limit, forced, grant;
  logic [15:0] wcnt;
`ifdef BUS_HOLD_EN
  assign hold_req = HOLD;
  assign HOLDA = state == TH;
`else
  logic unused_hold;
  assign unused_hold = HOLD;
  assign hold_req = 1'b0;
  assign HOLDA = 1'b0;
`endif
  always_comb begin
    active = state inside {T1, T2, T3, TW, T4};
    strobe = state inside {T2, T3, TW};
    ind_done = state == T4 && ind_q && (!word_q || byte_hi);
    pf_strobe = state == T4 && !ind_q && !disc && !flush;
    bus_timeout = state == T4 && to_q;
    word_cont = state == T4 && ind_q && word_q && !byte_hi;
    // the EU still holds ind_req during the T4 that completes it
    ind_win = ind_req && !ind_done;
    pf_win = pf_req && !suspend;
    arb = hold_req ? TH : (ind_win || pf_win) ? T1 : TI;
    limit = MAX_WAIT > 0 && state == TW && int'(wcnt) + 1 >= MAX_WAIT;
    forced = limit && !READY;
    nxt = state == TI ? arb :
          state == T1 ? T2 :
          state == T2 ? T3 :
          (state == T3 || state == TW) ? ((READY || limit) ? T4 : TW) :
          state == T4 ? (word_cont ? T1 : arb) :
          (state == TH && hold_req) ? TH : TI;
    grant = nxt == T1 && !word_cont;
    t_state = state;
    ALE = state == T1;
    DEN_n = !strobe;
    RD_n = !(strobe && !wr_q);
    WR_n = !(strobe && wr_q);
    DTR = active && wr_q;
    IOM = active && io_q;
    cyc_ind = active && ind_q;
  end
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= TI;
      ind_q <= 1'b0;
      io_q <= 1'b0;
      wr_q <= 1'b0;
      word_q <= 1'b0;
      byte_hi <= 1'b0;
      disc <= 1'b0;
      to_q <= 1'b0;
      wcnt <= '0;
    end else begin
      state <= nxt;
      if (grant) begin
        ind_q <= ind_win;
        io_q <= ind_win && ind_io;
        wr_q <= ind_win && ind_wr;
        word_q <= ind_win && ind_word;
      end
      byte_hi <= word_cont ? 1'b1 : ind_done ? 1'b0 : byte_hi;
      disc <= state == T4 ? 1'b0 : (flush && active && !ind_q) ? 1'b1 : disc;
      wcnt <= state == T3 ? '0 : state == TW ? wcnt + 16'd1 : wcnt;
      to_q <= forced;
    end
  end
endmodule
